channel_selector: RTL and testbench
===================================

CHANNEL_SELECTOR -- requirements
Module: channel_selector

Interface
REQ-001 Parameter WIDTH, default 8: bits per data channel, legal range 1..32.
REQ-002 Parameter CHANNELS, default 4: number of input channels, legal range 2..16.
REQ-003 Parameter DWELL, default 16: clock cycles spent on each channel in scan mode, legal range 1..65535.
REQ-004 Parameter SEL_W, derived as clog2(CHANNELS) and never overridden.
REQ-005 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port din, input, CHANNELS*WIDTH: packed channels, channel k at bits [k*WIDTH +: WIDTH].
REQ-008 Port sel, input, SEL_W: manual channel select.
REQ-009 Port mode, input, 1: 0 = manual, 1 = auto-scan.
REQ-010 Port hold, input, 1: freeze all outputs and internal counters.
REQ-011 Port q, output, WIDTH: registered selected data.
REQ-012 Port ch, output, SEL_W: channel index that produced q.
REQ-013 Port q_valid, output, 1: q holds sampled data.
REQ-014 Port switched, output, 1: single-cycle pulse when ch changes value.
REQ-015 Port sel_err, output, 1: registered flag, manual sel out of range.

Function
REQ-016 Two states, MANUAL (mode=0) and SCAN (mode=1), with the state register updated from mode each non-hold cycle.
REQ-017 Latency is exactly one cycle: q and ch reflect din and the selection sampled at the preceding rising edge.
REQ-018 Priority order on every edge is rst, then hold, then mode behaviour.
REQ-019 hold=1 keeps q, ch, q_valid, sel_err, state, and dwell counter unchanged, and forces switched=0.
REQ-020 MANUAL with sel<CHANNELS: q<=din[sel], ch<=sel, sel_err<=0, q_valid<=1.
REQ-021 MANUAL with sel>=CHANNELS (non-power-of-2 CHANNELS only): q, ch, and q_valid hold their values, and sel_err<=1.
REQ-022 SCAN: q<=din[ch_next], ch<=ch_next, q_valid<=1, sel_err<=0.
REQ-023 SCAN dwell counter counts 0..DWELL-1, and ch_next=ch+1 only when the counter equals DWELL-1; otherwise ch_next=ch.
REQ-024 SCAN channel wrap: CHANNELS-1 advances to 0; the counter wraps DWELL-1 to 0 on the same edge.
REQ-025 DWELL=1 advances ch on every non-hold cycle.
REQ-026 Transition MANUAL->SCAN: the first SCAN cycle uses the current ch, not sel, and clears the dwell counter to 0.
REQ-027 Transition SCAN->MANUAL: the first MANUAL cycle applies REQ-020/021 immediately, and the dwell counter clears to 0.
REQ-028 switched=1 for exactly the one cycle after any edge where ch's registered value changes, including a manual sel change; otherwise 0.
REQ-029 din changes without a selection change only update q; they never assert switched.

Reset
REQ-030 While rst=1: q=0, ch=0, q_valid=0, switched=0, sel_err=0, state=MANUAL, dwell counter=0, all asynchronously.
REQ-031 The first rising edge after rst deasserts performs a normal update per REQ-018..029, applied even mid-scan with no residual state.

Verification
REQ-032 Bench: WIDTH=8, CHANNELS=4, din=0x44_33_22_11, mode=0, sel=2 after reset -> next edge q=0x33, ch=2, q_valid=1, switched=1 for one cycle.
REQ-033 Bench: mode=1, DWELL=3, starting ch=2 -> ch sequence 2,2,2,3,3,3,0,0,0,1; switched pulses on each change, including 3->0 wrap.
REQ-034 Bench: in SCAN, assert hold for 5 cycles mid-dwell -> q, ch, and counter frozen; after release, remaining dwell cycles complete before ch advances.
REQ-035 Bench: CHANNELS=3, mode=0, sel=3 -> sel_err=1, q and ch unchanged; then sel=1 -> sel_err=0, q=din[1].
REQ-036 Bench: assert rst asynchronously between edges during SCAN -> all outputs 0 immediately; after release with mode=1, scan restarts at ch=0 with a full dwell.
REQ-037 Bench: change din only, with fixed sel -> q follows one cycle later, and switched stays 0.

Source files
------------

// File: rtl/channel_selector.sv
// Registered channel multiplexer with manual selection and timed auto-scan.
// Outputs lag the sampled inputs by one clock; hold freezes everything.
module channel_selector #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 16,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          q,
  output logic [SEL_W-1:0]          ch,
  output logic                      q_valid,
  output logic                      switched,
  output logic                      sel_err
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W:0]   CH_LIM   = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST  = SEL_W'(CHANNELS - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_base;
  logic [SEL_W-1:0]   ch_q, ch_d, ch_inc;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               switched_q, switched_d;
  logic               err_q, err_d;
  logic               sel_ok, load;
  logic [WIDTH-1:0]   chan [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign chan[gi] = din[gi*WIDTH +: WIDTH];
  end

  assign sel_ok = ({1'b0, sel} < CH_LIM);
  assign ch_inc = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
  // A fresh scan always starts its dwell from zero, whatever the counter held.
  assign cnt_base = (state_q == SCAN) ? cnt_q : '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ch_d       = ch_q;
    data_d     = data_q;
    valid_d    = valid_q;
    err_d      = err_q;
    switched_d = 1'b0;
    load       = 1'b0;
    if (!hold) begin
      if (!mode) begin
        state_d = MANUAL;
        cnt_d   = '0;
        if (sel_ok) begin
          ch_d    = sel;
          valid_d = 1'b1;
          err_d   = 1'b0;
          load    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        state_d = SCAN;
        valid_d = 1'b1;
        err_d   = 1'b0;
        load    = 1'b1;
        if (cnt_base == CNT_LAST) begin
          cnt_d = '0;
          ch_d  = ch_inc;
        end else begin
          cnt_d = cnt_base + CNT_W'(1);
        end
      end
      if (load) begin
        for (int k = 0; k < CHANNELS; k++) begin
          if (ch_d == SEL_W'(k)) data_d = chan[k];
        end
      end
      switched_d = (ch_d != ch_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MANUAL;
      cnt_q      <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      switched_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      switched_q <= switched_d;
      err_q      <= err_d;
    end
  end

  assign q        = data_q;
  assign ch       = ch_q;
  assign q_valid  = valid_q;
  assign switched = switched_q;
  assign sel_err  = err_q;

endmodule

// File: tb/tb_channel_selector.sv
// Bench for channel_selector: two instances (4 channels/dwell 3, 3 channels/dwell 2)
// share stimulus and are compared every cycle against an arithmetic model.
module tb_channel_selector;

  logic        clk, rst, mode, hold;
  logic [31:0] din;
  logic [1:0]  sel;

  logic [7:0] a_q, b_q;
  logic [1:0] a_ch, b_ch;
  logic       a_v, a_sw, a_err, b_v, b_sw, b_err;

  int checks = 0;
  int errors = 0;

  channel_selector #(.WIDTH(8), .CHANNELS(4), .DWELL(3)) dut_a (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .hold(hold),
    .q(a_q), .ch(a_ch), .q_valid(a_v), .switched(a_sw), .sel_err(a_err));

  channel_selector #(.WIDTH(8), .CHANNELS(3), .DWELL(2)) dut_b (
    .clk(clk), .rst(rst), .din(din[23:0]), .sel(sel), .mode(mode), .hold(hold),
    .q(b_q), .ch(b_ch), .q_valid(b_v), .switched(b_sw), .sel_err(b_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: in scan, the channel is the entry channel advanced by
  // (scan edges since entry) / DWELL, modulo the channel count.
  const int MCH[2] = '{4, 3};
  const int MDW[2] = '{3, 2};
  logic [7:0] m_q[2];
  int         m_ch[2], m_base[2], m_n[2];
  bit         m_v[2], m_sw[2], m_err[2], m_scan[2];

  function automatic logic [7:0] lane(input int k);
    return din[k*8 +: 8];
  endfunction

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_q[d] = 8'h00; m_ch[d] = 0; m_v[d] = 0; m_sw[d] = 0; m_err[d] = 0;
        m_scan[d] = 0; m_base[d] = 0; m_n[d] = 0;
      end else if (hold) begin
        m_sw[d] = 0;
      end else begin
        int nc;
        nc = m_ch[d];
        if (!mode) begin
          m_scan[d] = 0;
          if (int'(sel) < MCH[d]) begin
            nc = int'(sel); m_q[d] = lane(nc); m_v[d] = 1; m_err[d] = 0;
          end else begin
            m_err[d] = 1;
          end
        end else begin
          if (!m_scan[d]) begin
            m_scan[d] = 1; m_base[d] = m_ch[d]; m_n[d] = 0;
          end
          m_n[d] = m_n[d] + 1;
          nc = (m_base[d] + m_n[d] / MDW[d]) % MCH[d];
          m_q[d] = lane(nc); m_v[d] = 1; m_err[d] = 0;
        end
        m_sw[d] = (nc != m_ch[d]);
        m_ch[d] = nc;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("model_a_q", 32'(a_q), 32'(m_q[0]));
      check("model_a_ch", 32'(a_ch), 32'(m_ch[0]));
      check("model_a_valid", 32'(a_v), 32'(m_v[0]));
      check("model_a_switched", 32'(a_sw), 32'(m_sw[0]));
      check("model_a_sel_err", 32'(a_err), 32'(m_err[0]));
      check("model_b_q", 32'(b_q), 32'(m_q[1]));
      check("model_b_ch", 32'(b_ch), 32'(m_ch[1]));
      check("model_b_valid", 32'(b_v), 32'(m_v[1]));
      check("model_b_switched", 32'(b_sw), 32'(m_sw[1]));
      check("model_b_sel_err", 32'(b_err), 32'(m_err[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_zero(input string nm);
    check({nm, "_q"}, 32'(a_q), 32'h0);
    check({nm, "_ch"}, 32'(a_ch), 32'h0);
    check({nm, "_valid"}, 32'(a_v), 32'h0);
    check({nm, "_switched"}, 32'(a_sw), 32'h0);
    check({nm, "_sel_err"}, 32'(a_err), 32'h0);
  endtask

  int seq_ch[9] = '{2, 2, 3, 3, 3, 0, 0, 0, 1};
  int seq_sw[9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

  initial begin
    rst = 1'b1; mode = 1'b0; hold = 1'b0; sel = 2'd0; din = 32'h0;
    #1;
    check_a_zero("reset");
    tick(); tick();
    rst = 1'b0;
    din = 32'h44332211; sel = 2'd2; mode = 1'b0;

    tick();
    check("manual_q", 32'(a_q), 32'h33);
    check("manual_ch", 32'(a_ch), 32'd2);
    check("manual_valid", 32'(a_v), 32'd1);
    check("manual_switched", 32'(a_sw), 32'd1);
    tick();
    check("manual_switched_drop", 32'(a_sw), 32'd0);

    din = 32'h44AA2211;
    tick();
    check("din_only_q", 32'(a_q), 32'hAA);
    check("din_only_switched", 32'(a_sw), 32'd0);

    mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check($sformatf("scan_ch_%0d", i), 32'(a_ch), 32'(seq_ch[i]));
      check($sformatf("scan_sw_%0d", i), 32'(a_sw), 32'(seq_sw[i]));
    end

    tick();
    check("pre_hold_ch", 32'(a_ch), 32'd1);
    hold = 1'b1; din = 32'h55555555;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_ch_%0d", i), 32'(a_ch), 32'd1);
      check($sformatf("hold_q_%0d", i), 32'(a_q), 32'h22);
      check($sformatf("hold_sw_%0d", i), 32'(a_sw), 32'd0);
    end
    hold = 1'b0;
    tick();
    check("release_ch", 32'(a_ch), 32'd1);
    check("release_q", 32'(a_q), 32'h55);
    tick();
    check("release_adv_ch", 32'(a_ch), 32'd2);
    check("release_adv_sw", 32'(a_sw), 32'd1);

    mode = 1'b0; sel = 2'd0; din = 32'h44332211;
    tick();
    check("b_sel0_q", 32'(b_q), 32'h11);
    check("b_sel0_ch", 32'(b_ch), 32'd0);
    din = 32'h99887766; sel = 2'd3;
    tick();
    check("b_bad_sel_err", 32'(b_err), 32'd1);
    check("b_bad_sel_q", 32'(b_q), 32'h11);
    check("b_bad_sel_ch", 32'(b_ch), 32'd0);
    check("b_bad_sel_valid", 32'(b_v), 32'd1);
    check("a_sel3_q", 32'(a_q), 32'h99);
    check("a_sel3_err", 32'(a_err), 32'd0);
    sel = 2'd1;
    tick();
    check("b_good_sel_err", 32'(b_err), 32'd0);
    check("b_good_sel_q", 32'(b_q), 32'h77);
    check("b_good_sel_sw", 32'(b_sw), 32'd1);

    mode = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    #2 rst = 1'b1;
    #1;
    check_a_zero("async_rst");
    check("async_rst_b_q", 32'(b_q), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    check("rescan_ch0", 32'(a_ch), 32'd0);
    check("rescan_valid", 32'(a_v), 32'd1);
    tick();
    check("rescan_ch0b", 32'(a_ch), 32'd0);
    tick();
    check("rescan_ch1", 32'(a_ch), 32'd1);
    check("rescan_sw", 32'(a_sw), 32'd1);

    for (int i = 0; i < 2000; i++) begin
      din = $urandom;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
      hold = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
